reg_file_sweep: RTL and testbench

Parametrised successor to the 8x8 CPU register file: configurable data width and depth, one synchronous write port and two combinational read ports. Adds an optional same-cycle write-to-read bypass and an optional hard-wired zero register. Adds a multi-cycle CLEAR sweeper with BUSY/CLEAR_DONE handshake and a write-rejection flag. Sits between the control unit/ALU and the writeback mux in the single-cycle datapath. Contains no simulation delays or dump/monitor code.

---
 rtl/reg_file_sweep_pkg.sv | 13 +
 rtl/reg_file_sweep_if.sv | 29 ++
 rtl/reg_sweep_ctrl.sv | 68 ++++++
 rtl/reg_file_sweep.sv | 85 ++++++++
 tb/tb_reg_file_sweep.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sweep_pkg.sv
// Shared types and defaults for the sweeping register file.
package reg_file_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } sweep_state_e;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 3;

endpackage

// File: rtl/reg_file_sweep_if.sv
// Write/read/clear bus of the register file; master drives requests, slave returns data and status.
interface reg_file_sweep_if
    import reg_file_sweep_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
);
    logic              WRITE;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] OUT1ADDRESS;
    logic [ADDR_W-1:0] OUT2ADDRESS;
    logic [DATA_W-1:0] OUT1;
    logic [DATA_W-1:0] OUT2;
    logic              CLEAR;
    logic              BUSY;
    logic              CLEAR_DONE;
    logic              WRITE_ERR;

    modport master (
        output WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        input  OUT1, OUT2, BUSY, CLEAR_DONE, WRITE_ERR
    );

    modport slave (
        input  WRITE, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
        output OUT1, OUT2, BUSY, CLEAR_DONE, WRITE_ERR
    );
endinterface

// File: rtl/reg_sweep_ctrl.sv
// Clear-sweep sequencer: walks a pointer over every register, blocks writes meanwhile
// and flags the writes it drops.
module reg_sweep_ctrl
    import reg_file_sweep_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic              write_masked_i,
    input  logic              clear_i,
    output logic              write_accept_o,
    output logic              sweep_o,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              busy_o,
    output logic              clear_done_o,
    output logic              write_err_o
);
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'((1 << ADDR_W) - 1);

    sweep_state_e      state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Writes to a hard-wired zero register vanish silently, even mid-sweep.
            err_q  <= write_i && (state_q == StSweep) && !write_masked_i;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        state_q <= StSweep;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSweep: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LastPtr) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sweep_o        = (state_q == StSweep);
    assign write_accept_o = write_i && !rst_i && (state_q != StSweep);
    assign ptr_o          = ptr_q;
    assign busy_o         = busy_q;
    assign clear_done_o   = done_q;
    assign write_err_o    = err_q;

endmodule

// File: rtl/reg_file_sweep.sv
// Parametrised register file: one synchronous write port, two combinational read ports,
// optional write-to-read bypass, optional zero register and a multi-cycle clear sweep.
module reg_file_sweep
    import reg_file_sweep_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          ZERO_REG0 = 1'b0
) (
    input logic             CLK,
    input logic             RESET,
    reg_file_sweep_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];

    logic              write_accept;
    logic              write_masked;
    logic              write_en;
    logic              sweep_act;
    logic [ADDR_W-1:0] sweep_ptr;
    logic              busy;
    logic              clear_done;
    logic              write_err;

    assign write_masked = ZERO_REG0 && (bus.INADDRESS == '0);
    assign write_en     = write_accept && !write_masked;

    reg_sweep_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk_i          (CLK),
        .rst_i          (RESET),
        .write_i        (bus.WRITE),
        .write_masked_i (write_masked),
        .clear_i        (bus.CLEAR),
        .write_accept_o (write_accept),
        .sweep_o        (sweep_act),
        .ptr_o          (sweep_ptr),
        .busy_o         (busy),
        .clear_done_o   (clear_done),
        .write_err_o    (write_err)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Sweep and accepted write are mutually exclusive, so they never collide.
            if (sweep_act) begin
                regs_q[sweep_ptr] <= '0;
            end
            if (write_en) begin
                regs_q[bus.INADDRESS] <= bus.IN;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
        if (BYPASS) begin
            if (write_en && (bus.INADDRESS == addr)) begin
                val = bus.IN;
            end else if (sweep_act && (sweep_ptr == addr)) begin
                val = '0;
            end
        end
        if (ZERO_REG0 && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    assign bus.OUT1       = read_port(bus.OUT1ADDRESS);
    assign bus.OUT2       = read_port(bus.OUT2ADDRESS);
    assign bus.BUSY       = busy;
    assign bus.CLEAR_DONE = clear_done;
    assign bus.WRITE_ERR  = write_err;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Three configurations driven in lockstep and checked every cycle against a behavioural model.
module tb_reg_file_sweep;
    import reg_file_sweep_pkg::*;

    localparam int CfgAw  [3] = '{3, 3, 4};
    localparam int CfgByp [3] = '{1, 0, 1};
    localparam int CfgZ   [3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        s_wr = 1'b0;
    logic        s_clr = 1'b0;
    logic [3:0]  s_wa = '0;
    logic [3:0]  s_r1 = '0;
    logic [3:0]  s_r2 = '0;
    logic [15:0] s_wd = '0;

    int n_chk = 0;
    int n_err = 0;

    // Model state: registers, remaining sweep cycles, done pulse, error pulse.
    logic [15:0] m_mem  [3][16];
    int          m_left [3];
    bit          m_done [3];
    bit          m_err  [3];

    always #5 clk = ~clk;

    reg_file_sweep_if #(.DATA_W(8),  .ADDR_W(3)) ifa ();
    reg_file_sweep_if #(.DATA_W(8),  .ADDR_W(3)) ifb ();
    reg_file_sweep_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

    assign ifa.WRITE = s_wr;       assign ifb.WRITE = s_wr;       assign ifc.WRITE = s_wr;
    assign ifa.CLEAR = s_clr;      assign ifb.CLEAR = s_clr;      assign ifc.CLEAR = s_clr;
    assign ifa.INADDRESS = s_wa[2:0];   assign ifb.INADDRESS = s_wa[2:0];   assign ifc.INADDRESS = s_wa;
    assign ifa.OUT1ADDRESS = s_r1[2:0]; assign ifb.OUT1ADDRESS = s_r1[2:0]; assign ifc.OUT1ADDRESS = s_r1;
    assign ifa.OUT2ADDRESS = s_r2[2:0]; assign ifb.OUT2ADDRESS = s_r2[2:0]; assign ifc.OUT2ADDRESS = s_r2;
    assign ifa.IN = s_wd[7:0];     assign ifb.IN = s_wd[7:0];     assign ifc.IN = s_wd;

    reg_file_sweep #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG0(1'b0)) dut_a (
        .CLK (clk), .RESET (s_rst), .bus (ifa.slave));
    reg_file_sweep #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG0(1'b0)) dut_b (
        .CLK (clk), .RESET (s_rst), .bus (ifb.slave));
    reg_file_sweep #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG0(1'b1)) dut_c (
        .CLK (clk), .RESET (s_rst), .bus (ifc.slave));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] dmask(input int k);
        return (k == 2) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] m_read(input int k, input logic [3:0] addr);
        int depth, a, wa, left;
        depth = 1 << CfgAw[k];
        a     = int'(addr) & (depth - 1);
        wa    = int'(s_wa) & (depth - 1);
        left  = m_left[k];
        if (CfgZ[k] != 0 && a == 0) return 16'h0;
        if (CfgByp[k] != 0 && s_wr && !s_rst && left == 0 && wa == a) return s_wd & dmask(k);
        if (CfgByp[k] != 0 && left > 0 && depth - left == a) return 16'h0;
        return m_mem[k][a];
    endfunction

    function automatic void m_step(input int k);
        int depth, a, left;
        bit masked, was_done;
        depth    = 1 << CfgAw[k];
        a        = int'(s_wa) & (depth - 1);
        left     = m_left[k];
        masked   = (CfgZ[k] != 0) && (a == 0);
        was_done = m_done[k];
        if (s_rst) begin
            for (int i = 0; i < 16; i++) m_mem[k][i] = 16'h0;
            m_left[k] = 0;
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            return;
        end
        m_err[k]  = s_wr && left > 0 && !masked;
        m_done[k] = (left == 1);
        if (left > 0) begin
            m_mem[k][depth - left] = 16'h0;
            m_left[k] = left - 1;
        end else begin
            if (s_wr && !masked) m_mem[k][a] = s_wd & dmask(k);
            if (s_clr && !was_done) m_left[k] = depth;
        end
    endfunction

    task automatic compare_all();
        chk("a_out1", {8'h0, ifa.OUT1}, m_read(0, s_r1));
        chk("a_out2", {8'h0, ifa.OUT2}, m_read(0, s_r2));
        chk("a_busy", 16'(ifa.BUSY), 16'(m_left[0] > 0));
        chk("a_done", 16'(ifa.CLEAR_DONE), 16'(m_done[0]));
        chk("a_werr", 16'(ifa.WRITE_ERR), 16'(m_err[0]));
        chk("b_out1", {8'h0, ifb.OUT1}, m_read(1, s_r1));
        chk("b_out2", {8'h0, ifb.OUT2}, m_read(1, s_r2));
        chk("b_busy", 16'(ifb.BUSY), 16'(m_left[1] > 0));
        chk("b_done", 16'(ifb.CLEAR_DONE), 16'(m_done[1]));
        chk("b_werr", 16'(ifb.WRITE_ERR), 16'(m_err[1]));
        chk("c_out1", ifc.OUT1, m_read(2, s_r1));
        chk("c_out2", ifc.OUT2, m_read(2, s_r2));
        chk("c_busy", 16'(ifc.BUSY), 16'(m_left[2] > 0));
        chk("c_done", 16'(ifc.CLEAR_DONE), 16'(m_done[2]));
        chk("c_werr", 16'(ifc.WRITE_ERR), 16'(m_err[2]));
    endtask

    // One clock: compare mid-cycle, advance model on the edge, return just after it.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k);
        #1;
    endtask

    int busy_a, busy_c, done_a, done_c, err_a;

    initial begin
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k);
        #1;
        cyc();
        s_rst = 1'b0;
        s_r1 = 4'd3;
        #1;
        chk("reset_r3", {8'h0, ifa.OUT1}, 16'h0000);
        chk("reset_busy", 16'(ifa.BUSY), 16'h0);

        // Write 5A to r3 and read it back.
        s_wr = 1'b1; s_wa = 4'd3; s_wd = 16'h005A;
        cyc();
        s_wr = 1'b0; s_r1 = 4'd3; s_r2 = 4'd0;
        #1;
        chk("rd_r3", {8'h0, ifa.OUT1}, 16'h005A);
        chk("rd_r0", {8'h0, ifa.OUT2}, 16'h0000);
        cyc();

        // Same-cycle bypass on r5.
        s_wr = 1'b1; s_wa = 4'd5; s_wd = 16'h00C3; s_r2 = 4'd5;
        #1;
        chk("byp_on", {8'h0, ifa.OUT2}, 16'h00C3);
        chk("byp_off_old", {8'h0, ifb.OUT2}, 16'h0000);
        chk("byp_wide", ifc.OUT2, 16'h00C3);
        cyc();
        s_wr = 1'b0;
        #1;
        chk("byp_off_new", {8'h0, ifb.OUT2}, 16'h00C3);
        cyc();

        // Fill r0..r7 with 11..88, then sweep.
        for (int i = 0; i < 8; i++) begin
            s_wr = 1'b1; s_wa = 4'(i); s_wd = 16'((i + 1) * 16'h11);
            cyc();
        end
        s_wr = 1'b0; s_clr = 1'b1; s_r1 = 4'd7; s_r2 = 4'd2;
        cyc();
        s_clr = 1'b0;
        busy_a = 0; busy_c = 0; done_a = 0; done_c = 0; err_a = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (ifa.BUSY) busy_a++;
            if (ifc.BUSY) busy_c++;
            if (ifa.CLEAR_DONE) done_a++;
            if (ifc.CLEAR_DONE) done_c++;
            if (ifa.WRITE_ERR) err_a++;
            if (ifb.BUSY) chk("b_r7_hold", {8'h0, ifb.OUT1}, 16'h0088);
            s_wr = (i == 2); s_wa = 4'd2; s_wd = 16'h00FF;
            cyc();
        end
        s_wr = 1'b0;
        #1;
        chk("sweep_len8", 16'(busy_a), 16'd8);
        chk("sweep_len16", 16'(busy_c), 16'd16);
        chk("done_once_a", 16'(done_a), 16'd1);
        chk("done_once_c", 16'(done_c), 16'd1);
        chk("werr_once", 16'(err_a), 16'd1);
        chk("r7_cleared", {8'h0, ifa.OUT1}, 16'h0000);
        chk("r2_cleared", {8'h0, ifb.OUT2}, 16'h0000);

        // Reset in the third sweep cycle with r6 still holding 66.
        s_wr = 1'b1; s_wa = 4'd6; s_wd = 16'h0066;
        cyc();
        s_wr = 1'b0; s_clr = 1'b1;
        cyc();
        s_clr = 1'b0; s_r1 = 4'd6;
        cyc();
        cyc();
        s_rst = 1'b1;
        cyc();
        s_rst = 1'b0;
        #1;
        chk("rst_busy", 16'(ifa.BUSY), 16'h0);
        chk("rst_r6_a", {8'h0, ifa.OUT1}, 16'h0000);
        chk("rst_r6_b", {8'h0, ifb.OUT1}, 16'h0000);
        done_a = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (ifa.CLEAR_DONE || ifc.CLEAR_DONE) done_a++;
            cyc();
        end
        chk("rst_no_done", 16'(done_a), 16'd0);

        // Zero register and wide configuration.
        s_wr = 1'b1; s_wa = 4'd0; s_wd = 16'h00AA; s_r1 = 4'd0;
        #1;
        chk("z_r0_byp", ifc.OUT1, 16'h0000);
        cyc();
        s_wr = 1'b0;
        #1;
        chk("z_r0_read", ifc.OUT1, 16'h0000);
        chk("z_r0_werr", 16'(ifc.WRITE_ERR), 16'h0);
        chk("nz_r0_read", {8'h0, ifa.OUT1}, 16'h00AA);
        s_wr = 1'b1; s_wa = 4'd15; s_wd = 16'hBEEF;
        cyc();
        s_wr = 1'b0; s_r2 = 4'd15;
        #1;
        chk("wide_r15", ifc.OUT2, 16'hBEEF);
        cyc();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            s_rst = ($urandom_range(0, 63) == 0);
            s_wr  = 1'($urandom_range(0, 1));
            s_clr = ($urandom_range(0, 15) == 0);
            s_wa  = 4'($urandom);
            s_wd  = 16'($urandom);
            s_r1  = ($urandom_range(0, 3) == 0) ? s_wa : 4'($urandom);
            s_r2  = 4'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
